// File: rtl/jtdd_colmix_pkg.sv
// Shared constants for the jtdd colour mixer: layer selects, palette index prefixes and
// the pixel pipeline depth.
package jtdd_colmix_pkg;

    localparam logic [1:0] LYR_CHAR = 2'd0;
    localparam logic [1:0] LYR_SCR  = 2'd1;
    localparam logic [1:0] LYR_OBJ  = 2'd2;

    localparam logic [1:0] PRE_CHAR = 2'b00;
    localparam logic [1:0] PRE_SCR  = 2'b01;
    localparam logic       PRE_OBJ  = 1'b1;

    localparam int unsigned PIPE_DLY = 3;

endpackage

// File: rtl/jtdd_prio.sv
// Combinational layer priority (char > obj > scroll) and 9-bit palette index generation.
module jtdd_prio
    import jtdd_colmix_pkg::*;
(
    input  logic [7:0] char_pxl,
    input  logic [7:0] scr_pxl,
    input  logic [7:0] obj_pxl,
    input  logic [2:0] lyr_en,
    output logic [8:0] idx
);

    logic [1:0] lyr;
    logic       unused_bits;

    assign unused_bits = ^{char_pxl[7], scr_pxl[7]};

    always_comb begin
        lyr = LYR_SCR;
        if (lyr_en[0] && char_pxl[3:0] != 4'd0) begin
            lyr = LYR_CHAR;
        end else if (lyr_en[2] && obj_pxl[3:0] != 4'd0) begin
            lyr = LYR_OBJ;
        end
    end

    always_comb begin
        idx = '0;
        case (lyr)
            LYR_CHAR: idx = {PRE_CHAR, char_pxl[6:0]};
            LYR_OBJ:  idx = {PRE_OBJ, obj_pxl};
            // A disabled scroll layer behind transparent pixels falls back to index 0
            default:  idx = lyr_en[1] ? {PRE_SCR, scr_pxl[6:0]} : 9'd0;
        endcase
    end

endmodule

// File: rtl/jtframe_dual_ram.sv
// Dual-port RAM: port 0 read/write, port 1 read-only, both with registered
// read-before-write output and a per-port clock enable.
module jtframe_dual_ram #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 9
) (
    input  logic          clk,
    input  logic          cen0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] data0,
    input  logic          we0,
    output logic [DW-1:0] q0,
    input  logic          cen1,
    input  logic [AW-1:0] addr1,
    output logic [DW-1:0] q1
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (cen0) begin
            q0 <= mem[addr0];
            if (we0) mem[addr0] <= data0;
        end
    end

    always_ff @(posedge clk) begin
        if (cen1) q1 <= mem[addr1];
    end

endmodule

// File: rtl/jtdd_colmix.sv
// Colour mixer: 3-stage pixel pipeline (latch, priority + palette read, RGB) with CPU palette.
// Define JTDD_LAYER_EN to add the gfx_en per-layer enable input.
module jtdd_colmix
    import jtdd_colmix_pkg::*;
#(
    parameter string SIMFILE_RG = "",
    parameter string SIMFILE_B  = ""
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic       cpu_cen,
    input  logic [9:0] cpu_AB,
    input  logic       pal_cs,
    input  logic       cpu_wrn,
    input  logic [7:0] cpu_dout,
    output logic [7:0] pal_dout,
    input  logic [7:0] char_pxl,
    input  logic [7:0] scr_pxl,
    input  logic [7:0] obj_pxl,
`ifdef JTDD_LAYER_EN
    input  logic [2:0] gfx_en,
`endif
    input  logic       LHBL,
    input  logic       LVBL,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       LHBL_dly,
    output logic       LVBL_dly
);

    logic [7:0]          char_s0, scr_s0, obj_s0;
    logic [PIPE_DLY-1:0] hb_sr, vb_sr;
    logic [8:0]          vid_idx;
    logic [7:0]          vid_rg, vid_b, cpu_rg, cpu_b;
    logic [2:0]          lyr_en;
    logic                pal_wr, rd_bank, rd_vld;
    logic                unused_bits;

`ifdef JTDD_LAYER_EN
    assign lyr_en = gfx_en;
`else
    assign lyr_en = 3'b111;
`endif

    assign pal_wr      = pal_cs & ~cpu_wrn & cpu_cen;
    assign unused_bits = ^vid_b[7:4];

    always_ff @(posedge clk) begin
        if (rst) begin
            char_s0 <= '0;
            scr_s0  <= '0;
            obj_s0  <= '0;
            hb_sr   <= '0;
            vb_sr   <= '0;
            red     <= '0;
            green   <= '0;
            blue    <= '0;
        end else if (pxl_cen) begin
            char_s0 <= char_pxl;
            scr_s0  <= scr_pxl;
            obj_s0  <= obj_pxl;
            hb_sr   <= {hb_sr[PIPE_DLY-2:0], LHBL};
            vb_sr   <= {vb_sr[PIPE_DLY-2:0], LVBL};
            // Blank flags at the palette-output stage gate the RGB register
            if (hb_sr[PIPE_DLY-2] & vb_sr[PIPE_DLY-2]) begin
                red   <= vid_rg[3:0];
                green <= vid_rg[7:4];
                blue  <= vid_b[3:0];
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

    assign LHBL_dly = hb_sr[PIPE_DLY-1];
    assign LVBL_dly = vb_sr[PIPE_DLY-1];

    jtdd_prio u_prio (
        .char_pxl (char_s0),
        .scr_pxl  (scr_s0),
        .obj_pxl  (obj_s0),
        .lyr_en   (lyr_en),
        .idx      (vid_idx)
    );

    // The video port register is the S1 stage, so it only advances on pxl_cen
    jtframe_dual_ram #(.DW(8), .AW(9)) u_pal_rg (
        .clk   (clk),
        .cen0  (1'b1),
        .addr0 (cpu_AB[8:0]),
        .data0 (cpu_dout),
        .we0   (pal_wr & ~cpu_AB[9]),
        .q0    (cpu_rg),
        .cen1  (pxl_cen),
        .addr1 (vid_idx),
        .q1    (vid_rg)
    );

    jtframe_dual_ram #(.DW(8), .AW(9)) u_pal_b (
        .clk   (clk),
        .cen0  (1'b1),
        .addr0 (cpu_AB[8:0]),
        .data0 (cpu_dout),
        .we0   (pal_wr & cpu_AB[9]),
        .q0    (cpu_b),
        .cen1  (pxl_cen),
        .addr1 (vid_idx),
        .q1    (vid_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bank <= 1'b0;
            rd_vld  <= 1'b0;
        end else begin
            rd_bank <= cpu_AB[9];
            rd_vld  <= 1'b1;
        end
    end

    always_comb begin
        pal_dout = 8'd0;
        if (rd_vld) pal_dout = rd_bank ? cpu_b : cpu_rg;
    end

endmodule
